video_timing_monitor: RTL and testbench
=======================================

# video_timing_monitor

Receiving end of the `video_if` link. Samples HS/VS/BLANK/RGB from a video source, measures active and total line/frame geometry, and compares it to the expected HDISP/VDISP timing. Reports lock status, a saturating error count and an optional per-frame pixel checksum. Sits beside the VGA timing generator as an in-system self-check, and serves as the scoreboard front-end in video benches.

## Interface
- `HDISP`, 800, expected active pixels per line
- `VDISP`, 480, expected active lines per frame
- `pixel_clk`  in  1  pixel clock; all logic on its rising edge
- `pixel_rst`  in  1  reset; synchronous, active-high
- `vid_hs`  in  1  line sync; active low
- `vid_vs`  in  1  frame sync; active low
- `vid_blank`  in  1  1 = active pixel, 0 = blanking
- `vid_rgb`  in  24  pixel {R,G,B}; meaningful only when `vid_blank`=1
- `meas_hactive`  out  12  active pixels of the last complete line
- `meas_htotal`  out  12  clocks between the last two HS falling edges
- `meas_vactive`  out  12  lines with at least one active pixel in the last frame
- `meas_vtotal`  out  12  HS falling edges in the last frame
- `frame_done`  out  1  one-cycle pulse when frame measurements update
- `locked`  out  1  geometry matched expectation on 2 consecutive frames
- `err_cnt`  out  8  mismatching frames seen while LOCKED; saturates at 255
- `frame_sum`  out  32  pixel checksum of the last frame (see Configuration)

## Operation
- Input stage: all `vid_*` inputs are registered once; a second register holds the previous HS/VS for falling-edge detection.
- Horizontal counter `hcnt`:
  - increments every cycle;
  - on an HS falling edge, `meas_hactive` ← active count of the line and `meas_htotal` ← `hcnt`+1, then both counters clear.
- Line active count: increments while registered blank = 1.
- Vertical counters:
  - `vcnt` increments on each HS falling edge;
  - `vact` increments on an HS falling edge whose closing line had active count > 0.
- Frame close on a VS falling edge:
  - `meas_vactive` ← `vact`, `meas_vtotal` ← `vcnt`, `frame_sum` latched;
  - `frame_done` pulses; vertical counters clear.
- All counters are 12-bit and saturate at 4095; they never wrap.
- Frame match:
  - `meas_hactive`=HDISP, `meas_htotal`=HTOTAL, `meas_vactive`=VDISP, `meas_vtotal`=VTOTAL;
  - HTOTAL = HDISP+128, VTOTAL = VDISP+45, from package porch constants.
- FSM states SEARCH, MEASURE, CHECK, LOCKED:
  - SEARCH → MEASURE on the first VS fall. That frame is partial, so no compare is made.
  - MEASURE → CHECK on VS fall with match; on mismatch, stay in MEASURE.
  - CHECK → LOCKED on VS fall with match; on mismatch, go to MEASURE.
  - LOCKED: a match stays LOCKED. A mismatch increments `err_cnt` and goes to MEASURE.
  - Any state → SEARCH when `hcnt` or `vcnt` saturates (sync lost). `locked` drops the same cycle.
- `locked` = 1 only in LOCKED.
- Simultaneous HS and VS falling edges: the line closes first and is counted in the closing frame.
- Reset values:
  - all `meas_*`, `err_cnt`, `frame_sum` = 0; `frame_done` = 0; `locked` = 0;
  - FSM = SEARCH; edge registers = 1, so no spurious edge is detected after reset.

## Timing
- Input falling edge at cycle n: edge detected at n+1; `meas_*` / `frame_sum` / `locked` / `err_cnt` updated and `frame_done`=1 at n+2.
- `frame_done` high for exactly one cycle per VS falling edge, including in SEARCH.
- Reset asserted mid-frame: all state returns to reset values on the next edge. Relock needs 1 partial frame + 2 matching frames (third VS fall after reset).

## Configuration
- `VIDEO_TIMING_MONITOR_CHECKSUM_EN` defined:
  - 32-bit accumulator adds {8'h00, rgb} on every active pixel, modulo 2^32;
  - accumulator is latched to `frame_sum` and cleared at frame close.
- Not defined: no accumulator; `frame_sum` is tied to 0.

## Structure
- Package `video_timing_pkg` holds:
  - HFP=40, HPULSE=48, HBP=40, VFP=13, VPULSE=3, VBP=29;
  - derived margins and totals;
  - the monitor state enum typedef.
- Sub-module `sat_counter` (parameterised width, inc, clr, saturated flag), used for `hcnt`, `vcnt`, `vact` and line active count.

## Test plan
- Nominal 800×480 stream (htotal 928, vtotal 525), 4 frames -> `meas_*` = 800/928/480/525; `locked` rises 2 cycles after the third VS fall; `err_cnt`=0.
- Lock, then one line stretched to 929 clocks -> at that frame's close `locked`=0, `err_cnt`=1; relock after 2 clean frames.
- HS held high for 5000 clocks while locked -> `locked`=0 within the cycle `hcnt` hits 4095; FSM in SEARCH; `meas_*` unchanged.
- HS and VS fall in the same cycle -> `meas_vtotal` includes that line (525 for nominal stream).
- Checksum enabled, bench drives a white grid (x%16==0 or y%16==0, else black) aligned to blank -> `frame_sum` = 32'hA3FF4A5C; macro undefined -> 0.
- `pixel_rst` pulsed mid-frame while locked -> next cycle all outputs 0, `locked`=0; relock at third VS fall.

Source files
------------

// File: rtl/video_timing_monitor_pkg.sv
// Shared timing constants, monitor state encoding and saturating helpers for
// the video timing monitor.
package video_timing_pkg;

    // Horizontal and vertical porch/sync widths of the supported mode family.
    localparam int HFP    = 40;
    localparam int HPULSE = 48;
    localparam int HBP    = 40;
    localparam int VFP    = 13;
    localparam int VPULSE = 3;
    localparam int VBP    = 29;

    // Blanking margins added to the active size to obtain total line/frame length.
    localparam int HMARGIN = HFP + HPULSE + HBP;
    localparam int VMARGIN = VFP + VPULSE + VBP;

    localparam int CNT_W = 12;
    localparam int RGB_W = 24;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        CHECK   = 2'd2,
        LOCKED  = 2'd3
    } mon_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/video_timing_monitor_if.sv
// Video link carrying HS/VS (active low), BLANK (1 = active pixel) and RGB.
interface video_if;
    import video_timing_pkg::*;

    logic             hs;
    logic             vs;
    logic             blank;
    logic [RGB_W-1:0] rgb;

    modport master (output hs, vs, blank, rgb);
    modport slave  (input  hs, vs, blank, rgb);
endinterface

// File: rtl/video_timing_monitor_sat_counter.sv
// Up-counter that sticks at all-ones; clear takes priority over increment.
module sat_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             saturated
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    assign saturated = (count_reg == {WIDTH{1'b1}});
    assign count     = count_reg;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && !saturated) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/video_timing_monitor.sv
// Measures incoming video geometry, tracks lock against HDISP/VDISP timing and
// counts mismatching frames. Optional checksum: VIDEO_TIMING_MONITOR_CHECKSUM_EN.
module video_timing_monitor
    import video_timing_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480
) (
    input  logic             pixel_clk,
    input  logic             pixel_rst,
    video_if.slave           vid,
    output logic [CNT_W-1:0] meas_hactive,
    output logic [CNT_W-1:0] meas_htotal,
    output logic [CNT_W-1:0] meas_vactive,
    output logic [CNT_W-1:0] meas_vtotal,
    output logic             frame_done,
    output logic             locked,
    output logic [7:0]       err_cnt,
    output logic [31:0]      frame_sum
);

    localparam logic [CNT_W-1:0] HDISP_C  = CNT_W'(HDISP);
    localparam logic [CNT_W-1:0] VDISP_C  = CNT_W'(VDISP);
    localparam logic [CNT_W-1:0] HTOTAL_C = CNT_W'(HDISP + HMARGIN);
    localparam logic [CNT_W-1:0] VTOTAL_C = CNT_W'(VDISP + VMARGIN);

    // Counter slots: pixel-in-line, active-in-line, lines, active lines.
    localparam int N_CNT = 4;
    localparam int C_H   = 0;
    localparam int C_L   = 1;
    localparam int C_V   = 2;
    localparam int C_A   = 3;
    // Only the free-running line and frame counters indicate lost sync.
    localparam logic [N_CNT-1:0] SYNC_MASK = 4'b0101;

    logic hs_reg, vs_reg, blank_reg;
    logic hs_prev_reg, vs_prev_reg;
    logic hs_fall, vs_fall;

    logic [N_CNT-1:0] cnt_inc, cnt_clr, cnt_sat;
    logic [CNT_W-1:0] cnt_val [N_CNT];
    logic             line_active;
    logic             sync_lost;

    logic [CNT_W-1:0] meas_hactive_reg, meas_htotal_reg, meas_vactive_reg, meas_vtotal_reg;
    logic [CNT_W-1:0] hactive_next, htotal_next, vactive_next, vtotal_next;
    logic             frame_match;
    logic             frame_done_reg;

    mon_state_t state_reg, state_next;
    logic [7:0] err_reg, err_next;

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            blank_reg   <= 1'b0;
            hs_prev_reg <= 1'b1;
            vs_prev_reg <= 1'b1;
        end else begin
            hs_reg      <= vid.hs;
            vs_reg      <= vid.vs;
            blank_reg   <= vid.blank;
            hs_prev_reg <= hs_reg;
            vs_prev_reg <= vs_reg;
        end
    end

    assign hs_fall     = hs_prev_reg & ~hs_reg;
    assign vs_fall     = vs_prev_reg & ~vs_reg;
    assign line_active = (cnt_val[C_L] != '0);
    assign sync_lost   = |(cnt_sat & SYNC_MASK);

    assign cnt_inc[C_H] = 1'b1;
    assign cnt_clr[C_H] = hs_fall;
    assign cnt_inc[C_L] = blank_reg;
    assign cnt_clr[C_L] = hs_fall;
    assign cnt_inc[C_V] = hs_fall;
    assign cnt_clr[C_V] = vs_fall;
    assign cnt_inc[C_A] = hs_fall & line_active;
    assign cnt_clr[C_A] = vs_fall;

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            sat_counter #(.WIDTH(CNT_W)) u_cnt (
                .clk       (pixel_clk),
                .srst      (pixel_rst),
                .inc       (cnt_inc[gi]),
                .clr       (cnt_clr[gi]),
                .count     (cnt_val[gi]),
                .saturated (cnt_sat[gi])
            );
        end
    endgenerate

    // A line closing on the same cycle as VS belongs to the closing frame, so
    // the frame totals fold in that pending increment. The active width only
    // follows lines that carried pixels, so vertical blanking lines keep the
    // last real line width visible at frame close.
    always_comb begin
        hactive_next = meas_hactive_reg;
        htotal_next  = meas_htotal_reg;
        vactive_next = meas_vactive_reg;
        vtotal_next  = meas_vtotal_reg;
        if (hs_fall) begin
            htotal_next = sat_inc(cnt_val[C_H]);
            if (line_active) begin
                hactive_next = cnt_val[C_L];
            end
        end
        if (vs_fall) begin
            vtotal_next  = hs_fall ? sat_inc(cnt_val[C_V]) : cnt_val[C_V];
            vactive_next = (hs_fall && line_active) ? sat_inc(cnt_val[C_A]) : cnt_val[C_A];
        end
    end

    assign frame_match = (hactive_next == HDISP_C) && (htotal_next == HTOTAL_C) &&
                         (vactive_next == VDISP_C) && (vtotal_next == VTOTAL_C);

    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        if (sync_lost) begin
            state_next = SEARCH;
        end else if (vs_fall) begin
            case (state_reg)
                SEARCH:  state_next = MEASURE;
                MEASURE: state_next = frame_match ? CHECK : MEASURE;
                CHECK:   state_next = frame_match ? LOCKED : MEASURE;
                LOCKED: begin
                    if (!frame_match) begin
                        state_next = MEASURE;
                        if (err_reg != 8'hFF) begin
                            err_next = err_reg + 8'd1;
                        end
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state_reg        <= SEARCH;
            err_reg          <= '0;
            meas_hactive_reg <= '0;
            meas_htotal_reg  <= '0;
            meas_vactive_reg <= '0;
            meas_vtotal_reg  <= '0;
            frame_done_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            err_reg          <= err_next;
            meas_hactive_reg <= hactive_next;
            meas_htotal_reg  <= htotal_next;
            meas_vactive_reg <= vactive_next;
            meas_vtotal_reg  <= vtotal_next;
            frame_done_reg   <= vs_fall;
        end
    end

`ifdef VIDEO_TIMING_MONITOR_CHECKSUM_EN
    logic [RGB_W-1:0] rgb_reg;
    logic [31:0]      acc_reg, acc_next, sum_reg, sum_next, pix_val;

    always_comb begin
        pix_val  = blank_reg ? {8'h00, rgb_reg} : 32'h0;
        acc_next = acc_reg + pix_val;
        sum_next = sum_reg;
        if (vs_fall) begin
            sum_next = acc_next;
            acc_next = '0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            rgb_reg <= '0;
            acc_reg <= '0;
            sum_reg <= '0;
        end else begin
            rgb_reg <= vid.rgb;
            acc_reg <= acc_next;
            sum_reg <= sum_next;
        end
    end

    assign frame_sum = sum_reg;
`else
    assign frame_sum = '0;
`endif

    // Lock drops combinationally the moment a sync counter saturates.
    assign locked       = (state_reg == LOCKED) && !sync_lost;
    assign err_cnt      = err_reg;
    assign frame_done   = frame_done_reg;
    assign meas_hactive = meas_hactive_reg;
    assign meas_htotal  = meas_htotal_reg;
    assign meas_vactive = meas_vactive_reg;
    assign meas_vtotal  = meas_vtotal_reg;

endmodule

// File: tb/tb_video_timing_monitor.sv
// Scoreboard bench for video_timing_monitor on a reduced 8x4 mode (136x49 totals)
// driving a white grid; expected frame records are queued at each VS fall.
`timescale 1ns/1ps
module tb_video_timing_monitor;

    localparam int HDISP  = 8;
    localparam int VDISP  = 4;
    localparam int HT     = HDISP + 128;
    localparam int VT     = VDISP + 45;
    localparam int HS_X   = HDISP + 40;
    localparam int HS_LEN = 48;
    localparam int VS_Y   = VDISP + 13;
`ifdef VIDEO_TIMING_MONITOR_CHECKSUM_EN
    // 11 white pixels (column 0 and row 0 of an 8x4 field) of 24'hFFFFFF.
    localparam logic [31:0] SUM_EXP = 32'h0AFF_FFF5;
`else
    localparam logic [31:0] SUM_EXP = 32'h0;
`endif

    typedef struct {
        int          cyc;
        bit          full;
        logic [11:0] hact;
        logic [11:0] htot;
        logic [11:0] vact;
        logic [11:0] vtot;
        logic        lock;
        logic [7:0]  err;
        logic [31:0] sum;
    } exp_t;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst;
    logic [11:0] meas_hactive, meas_htotal, meas_vactive, meas_vtotal;
    logic        frame_done, locked;
    logic [7:0]  err_cnt;
    logic [31:0] frame_sum;

    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   frame_idx = 0;
    logic vs_drv    = 1'b1;
    exp_t cur_exp;
    exp_t sb_q[$];

    video_if vid ();

    video_timing_monitor #(.HDISP(HDISP), .VDISP(VDISP)) dut (
        .pixel_clk    (pixel_clk),
        .pixel_rst    (pixel_rst),
        .vid          (vid),
        .meas_hactive (meas_hactive),
        .meas_htotal  (meas_htotal),
        .meas_vactive (meas_vactive),
        .meas_vtotal  (meas_vtotal),
        .frame_done   (frame_done),
        .locked       (locked),
        .err_cnt      (err_cnt),
        .frame_sum    (frame_sum)
    );

    always #5 pixel_clk = ~pixel_clk;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge pixel_clk) begin : monitor
        exp_t e;
        if (pixel_rst !== 1'b1 && frame_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("frame_done_unexpected", 32'(frame_done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("frame %0d: cyc=%0d hact=%0d htot=%0d vact=%0d vtot=%0d locked=%0b err=%0d sum=%08h",
                         frame_idx, cyc, meas_hactive, meas_htotal, meas_vactive, meas_vtotal,
                         locked, err_cnt, frame_sum);
                frame_idx++;
                check("frame_done_latency", cyc, e.cyc);
                check("locked", 32'(locked), 32'(e.lock));
                check("err_cnt", 32'(err_cnt), 32'(e.err));
                if (e.full) begin
                    check("meas_hactive", 32'(meas_hactive), 32'(e.hact));
                    check("meas_htotal", 32'(meas_htotal), 32'(e.htot));
                    check("meas_vactive", 32'(meas_vactive), 32'(e.vact));
                    check("meas_vtotal", 32'(meas_vtotal), 32'(e.vtot));
                    check("frame_sum", frame_sum, e.sum);
                end
            end
        end
    end

    task automatic set_exp(input bit full, input int htot, input bit lock, input int err);
        cur_exp.cyc  = 0;
        cur_exp.full = full;
        cur_exp.hact = 12'(HDISP);
        cur_exp.htot = 12'(htot);
        cur_exp.vact = 12'(VDISP);
        cur_exp.vtot = 12'(VT);
        cur_exp.lock = lock;
        cur_exp.err  = 8'(err);
        cur_exp.sum  = SUM_EXP;
    endtask

    task automatic drive(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
        @(negedge pixel_clk);
        vid.hs    = hs;
        vid.vs    = vs;
        vid.blank = bl;
        vid.rgb   = rgb;
        if (vs_drv && !vs) begin
            cur_exp.cyc = cyc + 2;
            sb_q.push_back(cur_exp);
        end
        vs_drv = vs;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hactive"}, 32'(meas_hactive), 32'd0);
        check({tag, "_htotal"}, 32'(meas_htotal), 32'd0);
        check({tag, "_vactive"}, 32'(meas_vactive), 32'd0);
        check({tag, "_vtotal"}, 32'(meas_vtotal), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_frame_sum"}, frame_sum, 32'd0);
    endtask

    task automatic pulse_reset();
        pixel_rst = 1'b1;
        @(negedge pixel_clk);
        check_all_zero("midrst");
        pixel_rst = 1'b0;
    endtask

    // Sync held high while locked: the line counter must run into saturation.
    task automatic hold_sync();
        for (int k = 0; k < 5000; k++) begin
            drive(1'b1, 1'b1, 1'b0, 24'h0);
            if (k == 3900) check("hold_locked_before_sat", 32'(locked), 32'd1);
        end
        check("hold_locked_after_sat", 32'(locked), 32'd0);
        check("hold_hactive_kept", 32'(meas_hactive), 32'(HDISP));
        check("hold_htotal_kept", 32'(meas_htotal), 32'(HT));
        check("hold_vactive_kept", 32'(meas_vactive), 32'(VDISP));
        check("hold_vtotal_kept", 32'(meas_vtotal), 32'(VT));
    endtask

    // early=1 starts VS on the same cycle as the HS fall of line VS_Y-1.
    task automatic run_frame(input bit early, input int stretch_y, input int hold_y, input int rst_y);
        for (int y = 0; y < VT; y++) begin
            if (y == hold_y) hold_sync();
            for (int i = 0; i < HT + ((y == stretch_y) ? 1 : 0); i++) begin
                int          x;
                logic        hs_v, vs_v, bl_v;
                logic [23:0] rgb_v;
                x    = (y == stretch_y && i > HDISP) ? i - 1 : i;
                hs_v = !(x >= HS_X && x < HS_X + HS_LEN);
                if (early)
                    vs_v = !((y == VS_Y - 1 && x >= HS_X) || y == VS_Y || y == VS_Y + 1 ||
                             (y == VS_Y + 2 && x < HS_X));
                else
                    vs_v = !(y >= VS_Y && y < VS_Y + 3);
                bl_v  = (x < HDISP) && (y < VDISP);
                rgb_v = (bl_v && (x % 16 == 0 || y % 16 == 0)) ? 24'hFFFFFF : 24'h0;
                drive(hs_v, vs_v, bl_v, rgb_v);
                if (y == rst_y && i == 3) pulse_reset();
            end
        end
    endtask

    initial begin
        pixel_rst = 1'b1;
        vid.hs    = 1'b1;
        vid.vs    = 1'b1;
        vid.blank = 1'b0;
        vid.rgb   = 24'h0;
        repeat (3) @(negedge pixel_clk);
        check_all_zero("reset");
        pixel_rst = 1'b0;

        set_exp(1'b0, HT,     1'b0, 0); run_frame(1'b0, -1, -1, -1);
        set_exp(1'b1, HT,     1'b0, 0); run_frame(1'b0, -1, -1, -1);
        set_exp(1'b1, HT,     1'b1, 0); run_frame(1'b1, -1, -1, -1);
        set_exp(1'b1, HT,     1'b1, 0); run_frame(1'b0, -1, -1, -1);
        set_exp(1'b0, HT,     1'b0, 0); run_frame(1'b0, -1, -1,  2);
        set_exp(1'b1, HT,     1'b0, 0); run_frame(1'b0, -1, -1, -1);
        set_exp(1'b1, HT,     1'b1, 0); run_frame(1'b1, -1, -1, -1);
        set_exp(1'b1, HT + 1, 1'b0, 1); run_frame(1'b0, 16, -1, -1);
        set_exp(1'b1, HT,     1'b0, 1); run_frame(1'b0, -1, -1, -1);
        set_exp(1'b1, HT,     1'b1, 1); run_frame(1'b0, -1, -1, -1);
        set_exp(1'b1, HT,     1'b0, 1); run_frame(1'b0, -1, 10, -1);

        repeat (4) drive(1'b1, 1'b1, 1'b0, 24'h0);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(1_500_000);
        $display("FAIL watchdog: run still active at %0t, required completion earlier", $time);
        $fatal(1);
    end

endmodule
